qa_rx_line_unpacker: RTL and testbench
======================================

// Module: qa_rx_line_unpacker
//
// PURPOSE
//   Upstream feeder for the QA driver's client rx path. Accepts 512-bit CCI
//   channel-0 read-response cache lines, which cannot be back-pressured, and
//   buffers them in a small line FIFO. It serializes each line into
//   UMF_WIDTH chunks on the rx_data/rx_rdy/rx_enable client handshake.
//   A reservation counter gates the read-request issuer so buffered lines
//   plus in-flight reads never exceed buffer capacity.
//
// PARAMETERS
//   CACHE_WIDTH  512  width of one CCI cache line (bits)
//   UMF_WIDTH    128  width of one client chunk; CACHE_WIDTH % UMF_WIDTH == 0
//   N_LINES      4    line buffer depth; power of 2, >= 2
//   (derived) CHUNKS = CACHE_WIDTH/UMF_WIDTH; PTR_W = log2(N_LINES)
//
// PORTS
//   vl_clk_LPdomain_32ui             in   1            CCI clock, sole clock
//   ffs_vl_LP32ui_lp2sy_SoftReset_n  in   1            async active-low reset
//   line_valid                       in   1            read-response line valid (C0RxRdValid)
//   line_data                        in   CACHE_WIDTH  read-response line data
//   req_issue                        in   1            requester issues one line read this cycle
//   req_ok                           out  1            a read may be issued (reservation free)
//   rx_data                          out  UMF_WIDTH    current chunk to client
//   rx_rdy                           out  1            rx_data valid
//   rx_enable                        in   1            client consumes rx_data this cycle
//   occupancy                        out  PTR_W+1      lines held in buffer
//   overflow_err                     out  1            sticky protocol-violation flag
//
// BEHAVIOUR
//   Reset (async assert, sync release): wr_ptr=rd_ptr=chunk_idx=0;
//     count=0, reserved=0; rx_rdy=0, rx_data=0, req_ok=1, occupancy=0,
//     overflow_err=0.
//   Line write: line_valid && count<N_LINES -> store at wr_ptr; wr_ptr++, count++.
//     line_valid && count==N_LINES -> line dropped, overflow_err<=1.
//     Full is judged on the registered count; a same-cycle retire does not
//     free the slot for that write.
//   Output: rx_rdy = (count!=0), registered state only.
//     Line written at edge N -> rx_rdy=1 in cycle N+1 (1-cycle latency).
//     rx_data = buf[rd_ptr][chunk_idx*UMF_WIDTH +: UMF_WIDTH] when rx_rdy,
//     else 0. Chunk 0 is the least-significant slice.
//   Consume: rx_enable && rx_rdy -> chunk_idx++.
//     When chunk_idx==CHUNKS-1: chunk_idx<=0, rd_ptr++, count--, reserved-- (retire).
//     rx_enable while !rx_rdy is ignored (no state change, no error).
//   Pointers wrap modulo N_LINES; count distinguishes full from empty.
//   Reservation: reserved counts (lines buffered + reads in flight), range 0..N_LINES.
//     req_ok = (reserved < N_LINES).
//     req_issue && req_ok -> reserved++.
//     req_issue && !req_ok -> ignored, overflow_err<=1.
//     Simultaneous issue + retire -> reserved unchanged; req_ok uses pre-update value.
//     Line arrival does not change reserved.
//   Simultaneous write + retire: count unchanged; the write lands in the
//     slot at wr_ptr, the retire frees the slot at rd_ptr.
//   occupancy = count.
//   overflow_err clears only on reset.
//   Reset mid-line: partial chunk progress and all buffered lines are
//     discarded; the requester must reissue reads.
//
// TESTING
//   1. Reset, then req_issue x1 and line 0x..03_02_01_00 (chunk k = k), rx_enable held high
//      -> rx_rdy rises 1 cycle after the line; chunks 0,1,2,3 on 4 consecutive cycles;
//      occupancy returns to 0 and req_ok stays 1.
//   2. req_issue x4 with no consumption -> req_ok=0 after the 4th issue;
//      a 5th req_issue sets overflow_err=1 and reserved stays 4.
//   3. 4 lines arrive with rx_enable=0 -> occupancy=4; a 5th line_valid is
//      dropped and sets overflow_err; draining yields exactly the first 4 lines in order.
//   4. Line write and final-chunk consume in the same cycle with occupancy=2
//      -> occupancy stays 2, next rx_data is chunk 0 of the following line.
//   5. Stream of 10 lines with random rx_enable stalls and credit-gated issues
//      -> output chunk sequence matches input; pointer wrap correct; overflow_err stays 0.
//   6. Reset asserted after chunk 1 of a line has been consumed
//      -> all outputs take reset values immediately (async); the next line starts at chunk 0.

Source files
------------

// File: rtl/qa_rx_line_unpacker.sv
// rtl/qa_rx_line_unpacker.sv - buffers CCI read-response lines and serializes them to client chunks
// A reservation counter keeps buffered lines plus in-flight reads within buffer capacity.
module qa_rx_line_unpacker #(
  parameter int CACHE_WIDTH = 512,
  parameter int UMF_WIDTH   = 128,
  parameter int N_LINES     = 4
) (
  input  logic                         vl_clk_LPdomain_32ui,
  input  logic                         ffs_vl_LP32ui_lp2sy_SoftReset_n,
  input  logic                         line_valid,
  input  logic [CACHE_WIDTH-1:0]       line_data,
  input  logic                         req_issue,
  output logic                         req_ok,
  output logic [UMF_WIDTH-1:0]         rx_data,
  output logic                         rx_rdy,
  input  logic                         rx_enable,
  output logic [$clog2(N_LINES):0]     occupancy,
  output logic                         overflow_err
);

  localparam int CHUNKS  = CACHE_WIDTH / UMF_WIDTH;
  localparam int PTR_W   = $clog2(N_LINES);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [CACHE_WIDTH-1:0] lineBuf [N_LINES];
  logic [UMF_WIDTH-1:0]   headChunks [CHUNKS];
  logic [PTR_W-1:0]       wrPtr;
  logic [PTR_W-1:0]       rdPtr;
  logic [CHUNK_W-1:0]     chunkIdx;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       reserved;
  logic                   overflowErr;

  logic full;
  logic lastChunk;
  logic consume;
  logic retire;
  logic writeEn;
  logic issueOk;
  logic resDec;
  logic protoErr;

  assign full      = (count == CNT_W'(N_LINES));
  assign rx_rdy    = (count != '0);
  assign req_ok    = (reserved < CNT_W'(N_LINES));
  assign occupancy = count;
  assign overflow_err = overflowErr;

  assign lastChunk = (chunkIdx == CHUNK_W'(CHUNKS - 1));
  assign consume   = rx_enable && rx_rdy;
  assign retire    = consume && lastChunk;
  // Full is judged on the registered count, so a same-cycle retire cannot make room.
  assign writeEn   = line_valid && !full;
  assign issueOk   = req_issue && req_ok;
  assign resDec    = retire && (reserved != '0);
  assign protoErr  = (line_valid && full) || (req_issue && !req_ok);

  for (genvar k = 0; k < CHUNKS; k++) begin : gChunk
    assign headChunks[k] = lineBuf[rdPtr][k*UMF_WIDTH +: UMF_WIDTH];
  end

  assign rx_data = rx_rdy ? headChunks[chunkIdx] : '0;

  // Line storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge vl_clk_LPdomain_32ui) begin
    if (writeEn) begin
      lineBuf[wrPtr] <= line_data;
    end
  end

  always_ff @(posedge vl_clk_LPdomain_32ui or negedge ffs_vl_LP32ui_lp2sy_SoftReset_n) begin
    if (!ffs_vl_LP32ui_lp2sy_SoftReset_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      chunkIdx    <= '0;
      count       <= '0;
      reserved    <= '0;
      overflowErr <= 1'b0;
    end else begin
      if (writeEn) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end

      if (consume) begin
        if (lastChunk) begin
          chunkIdx <= '0;
          rdPtr    <= rdPtr + PTR_W'(1);
        end else begin
          chunkIdx <= chunkIdx + CHUNK_W'(1);
        end
      end

      case ({writeEn, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case ({issueOk, resDec})
        2'b10:   reserved <= reserved + CNT_W'(1);
        2'b01:   reserved <= reserved - CNT_W'(1);
        default: reserved <= reserved;
      endcase

      if (protoErr) begin
        overflowErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qa_rx_line_unpacker.sv
// tb/tb_qa_rx_line_unpacker.sv - randomized bench with a queue-based line model for qa_rx_line_unpacker
module tb_qa_rx_line_unpacker;

  localparam int CW = 512;
  localparam int UW = 128;
  localparam int NL = 4;
  localparam int CH = CW / UW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_valid = 1'b0;
  logic [CW-1:0] line_data = '0;
  logic          req_issue = 1'b0;
  logic          req_ok;
  logic [UW-1:0] rx_data;
  logic          rx_rdy;
  logic          rx_enable = 1'b0;
  logic [2:0]    occupancy;
  logic          overflow_err;

  int total = 0;
  int bad = 0;

  logic [CW-1:0] mq[$];
  int            mChunk = 0;
  int            mRes = 0;
  bit            mOvf = 1'b0;

  always #5 clk = ~clk;

  qa_rx_line_unpacker #(.CACHE_WIDTH(CW), .UMF_WIDTH(UW), .N_LINES(NL)) dut (
    .vl_clk_LPdomain_32ui            (clk),
    .ffs_vl_LP32ui_lp2sy_SoftReset_n (rst_n),
    .line_valid                      (line_valid),
    .line_data                       (line_data),
    .req_issue                       (req_issue),
    .req_ok                          (req_ok),
    .rx_data                         (rx_data),
    .rx_rdy                          (rx_rdy),
    .rx_enable                       (rx_enable),
    .occupancy                       (occupancy),
    .overflow_err                    (overflow_err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of whole lines, a chunk cursor into the head line and a credit count.
  always @(posedge clk or negedge rst_n) begin : mdl
    bit wasFull;
    bit wasRdy;
    bit credit;
    if (!rst_n) begin
      mq.delete();
      mChunk = 0;
      mRes = 0;
      mOvf = 1'b0;
    end else begin
      wasFull = (mq.size() == NL);
      wasRdy  = (mq.size() != 0);
      credit  = (mRes < NL);
      if (rx_enable && wasRdy) begin
        if (mChunk == CH - 1) begin
          void'(mq.pop_front());
          mChunk = 0;
          if (mRes > 0) mRes--;
        end else begin
          mChunk++;
        end
      end
      if (line_valid) begin
        if (wasFull) mOvf = 1'b1;
        else mq.push_back(line_data);
      end
      if (req_issue) begin
        if (credit) mRes++;
        else mOvf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [CW-1:0] hd;
    logic [UW-1:0] expData;
    if (rst_n) begin
      expData = '0;
      if (mq.size() != 0) begin
        hd = mq[0];
        expData = hd[mChunk*UW +: UW];
      end
      chk("rx_rdy", 128'(rx_rdy), 128'(mq.size() != 0));
      chk("occupancy", 128'(occupancy), 128'(mq.size()));
      chk("req_ok", 128'(req_ok), 128'(mRes < NL));
      chk("overflow_err", 128'(overflow_err), 128'(mOvf));
      chk("rx_data", 128'(rx_data), 128'(expData));
    end
  end

  task automatic step(input bit lv, input logic [CW-1:0] ld, input bit ri, input bit en);
    line_valid = lv;
    line_data  = ld;
    req_issue  = ri;
    rx_enable  = en;
    @(negedge clk);
  endtask

  task automatic idle(input bit en);
    step(1'b0, '0, 1'b0, en);
  endtask

  function automatic logic [CW-1:0] rndLine();
    logic [CW-1:0] l;
    for (int i = 0; i < CW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    line_valid = 1'b0;
    req_issue = 1'b0;
    rx_enable = 1'b0;
    line_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rx_rdy", 128'(rx_rdy), 128'(0));
    chk("rst_rx_data", 128'(rx_data), 128'(0));
    chk("rst_req_ok", 128'(req_ok), 128'(1));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_overflow", 128'(overflow_err), 128'(0));
    rst_n = 1'b1;
  endtask

  initial begin : drv
    logic [CW-1:0] lnA;
    logic [CW-1:0] lnB;
    logic [CW-1:0] lnC;
    int issued;
    int sent;
    int pend;
    int cyc;
    bit lv;
    bit ri;
    logic [CW-1:0] ld;

    // Test 1: single line, chunk k holds value k
    doReset();
    lnA = '0;
    for (int k = 0; k < CH; k++) lnA[k*UW +: UW] = UW'(k);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, lnA, 1'b0, 1'b1);
    chk("t1_rdy_after_line", 128'(rx_rdy), 128'(1));
    chk("t1_chunk0", 128'(rx_data), 128'(0));
    for (int k = 1; k < CH; k++) begin
      idle(1'b1);
      chk($sformatf("t1_chunk%0d", k), 128'(rx_data), 128'(k));
    end
    idle(1'b1);
    chk("t1_occ_end", 128'(occupancy), 128'(0));
    chk("t1_req_ok_end", 128'(req_ok), 128'(1));

    // Test 2: credit exhaustion
    doReset();
    for (int i = 0; i < NL; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("t2_req_ok_low", 128'(req_ok), 128'(0));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t2_overflow", 128'(overflow_err), 128'(1));
    chk("t2_req_ok_still_low", 128'(req_ok), 128'(0));

    // Test 3: buffer full, fifth line dropped, drain in order
    doReset();
    for (int i = 0; i < NL; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < NL; i++) step(1'b1, rndLine(), 1'b0, 1'b0);
    chk("t3_occ_full", 128'(occupancy), 128'(4));
    step(1'b1, rndLine(), 1'b0, 1'b0);
    chk("t3_drop_overflow", 128'(overflow_err), 128'(1));
    chk("t3_occ_after_drop", 128'(occupancy), 128'(4));
    for (int i = 0; i < NL * CH; i++) idle(1'b1);
    chk("t3_occ_drained", 128'(occupancy), 128'(0));

    // Test 4: write and retire in the same cycle
    doReset();
    lnA = rndLine();
    lnB = rndLine();
    lnC = rndLine();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, lnA, 1'b0, 1'b0);
    step(1'b1, lnB, 1'b0, 1'b0);
    for (int i = 0; i < CH - 1; i++) idle(1'b1);
    step(1'b1, lnC, 1'b0, 1'b1);
    chk("t4_occ_kept", 128'(occupancy), 128'(2));
    chk("t4_next_chunk0", 128'(rx_data), 128'(lnB[UW-1:0]));
    for (int i = 0; i < 2 * CH; i++) idle(1'b1);

    // Test 5: random stream of 10 lines under credit gating and stalls
    doReset();
    issued = 0;
    sent = 0;
    pend = 0;
    cyc = 0;
    while (!(sent == 10 && mq.size() == 0) && cyc < 2000) begin
      ri = (issued < 10) && (mRes < NL) && ($urandom_range(0, 3) != 0);
      lv = (pend > 0) && ($urandom_range(0, 1) == 1);
      ld = lv ? rndLine() : '0;
      if (lv) begin
        sent++;
        pend--;
      end
      if (ri) begin
        issued++;
        pend++;
      end
      step(lv, ld, ri, $urandom_range(0, 2) != 0);
      cyc++;
    end
    chk("t5_completed_in_budget", 128'(cyc < 2000), 128'(1));
    chk("t5_overflow_clear", 128'(overflow_err), 128'(0));
    chk("t5_occ_end", 128'(occupancy), 128'(0));

    // Test 6: asynchronous reset mid-line
    doReset();
    lnA = rndLine();
    lnB = rndLine();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, lnA, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    line_valid = 1'b0;
    rx_enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rdy", 128'(rx_rdy), 128'(0));
    chk("t6_async_data", 128'(rx_data), 128'(0));
    chk("t6_async_occ", 128'(occupancy), 128'(0));
    chk("t6_async_req_ok", 128'(req_ok), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, lnB, 1'b0, 1'b0);
    chk("t6_restart_chunk0", 128'(rx_data), 128'(lnB[UW-1:0]));
    for (int i = 0; i < CH; i++) idle(1'b1);
    chk("t6_occ_end", 128'(occupancy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
